serdes_rx_deframer: RTL and testbench
=====================================

# serdes_rx_deframer

Receive-side deframer on the master 420T. It consumes the four 16-bit SERDES lanes from the radar slave link, recognises the three-word frame headers, and splits the payload into two streams. IQ-result frames are unpacked from packed 64-bit words into 48-bit I/Q samples. Energy frames are unpacked into one CFAR target record per word. It sits directly after the SERDES receive interface (lane-aligned, 8b/10b-decoded) and feeds the IQ accumulation path and the target-report path.

## Interface
Parameters:
- IQ_WORDS_MAX, 12288 — maximum payload words per IQ frame (16384 samples × 3/4).

Ports (one clock; reset is synchronous and active-high):
- I_sys_clk  in  1  — receive user clock, 156.25 MHz; all logic on its rising edge.
- I_rst  in  1  — synchronous, active-high reset.
- I_rx_is_k  in  1  — 1 = payload word; 0 = marker/idle word. Common to all lanes.
- I_rx1_dat / I_rx2_dat / I_rx3_dat / I_rx4_dat  in  16 each — lanes 1–4. Word W = {rx4, rx3, rx2, rx1}.
- O_iq_ena  out  1 — first sample valid.
- O_iq_i_dat / O_iq_q_dat  out  24 each — first sample.
- O_iq_ena2  out  1 — second sample valid (payload phase 2 only).
- O_iq_i_dat2 / O_iq_q_dat2  out  24 each — second sample.
- O_iq_frame_done  out  1 — one-cycle pulse at IQ frame close.
- O_iq_sample_cnt  out  16 — samples in the closed frame; valid with O_iq_frame_done.
- O_target_ena  out  1 — target record valid.
- O_mach_angle_info  out  16 — machine angle, from W[63:48].
- O_mode_info  out  3 — mode, from W[47:45].
- O_angle_info  out  5 — beam angle, from W[44:40].
- O_target_energy  out  24 — target energy, from W[39:16].
- O_target_range  out  13 — target range, from W[12:0].
- O_err  out  1 — one-cycle pulse on any framing error.
- O_err_cnt  out  16 — saturating error count.

## Operation
- Word classes, evaluated on the registered input word:
  - PAY: is_k = 1.
  - M1: is_k = 0 and W = 0x1c1c…1c.
  - M3: is_k = 0 and W = 0x3c…3c.
  - M5: is_k = 0 and W = 0x5c…5c.
  - M7: is_k = 0 and W = 0x7c…7c.
  - IDL: any other is_k = 0 word. This includes 0xc5bc… and marker words whose lanes disagree.
- States: S_IDLE, S_H1, S_H2, S_IQ, S_EN.
  - S_IDLE: M1 → S_H1. PAY → error (orphan payload, dropped). Anything else → stay.
  - S_H1: M3 → S_H2. M1 → stay. Anything else → error, S_IDLE.
  - S_H2: M5 → S_IQ, clears phase and counts. M7 → S_EN. M1 → S_H1. Anything else → error, S_IDLE.
  - S_IQ: PAY → unpack. IDL → close frame, S_IDLE. M1 → close frame, S_H1. M3/M5/M7 → close frame, error, S_IDLE.
  - S_EN: PAY → emit target record. IDL → S_IDLE. M1 → S_H1. Other markers → error, S_IDLE.
- IQ unpack: samples are a continuous MSB-first 48-bit stream {I[23:0], Q[23:0]}. Phase p cycles 0 → 1 → 2 → 0.
  - p = 0: sample A = W[63:16]; hold W[15:0].
  - p = 1: sample A = {held16, W[63:32]}; hold W[31:0].
  - p = 2: sample A = {held32, W[63:48]}; sample B = W[47:0].
- IQ frame close:
  - O_iq_frame_done pulses; O_iq_sample_cnt = samples emitted in the frame.
  - If p ≠ 0 at close: error, and held partial bits are discarded.
- IQ overrun: payload word number IQ_WORDS_MAX+1 and later are dropped. One error is raised per frame, on the first dropped word.
- Energy reserved bits: W[15:13] ≠ 0 → record still emitted, and error raised.
- O_err_cnt increments once per error cycle and saturates at 0xFFFF.
- Reset mid-frame: state, phase, held bits and sample count clear. No frame_done is generated.

## Timing
- Input registered once (stage 1); class decode and FSM in stage 2. All outputs are registered.
- Latency: input word to O_iq_ena / O_iq_ena2 / O_target_ena / O_err = 2 cycles.
- O_iq_frame_done appears 2 cycles after the closing word, coincident with its O_err if any.
- Every valid and pulse output is high for exactly one cycle per event. Data outputs hold their last value between valids.
- No back-pressure. One payload word per cycle is sustained indefinitely.
- Reset values: every output is 0, including O_err_cnt.

## Test plan
- IQ frame: M1, M3, M5, then 3 PAY words packing samples 0x000001_000002, 0x000003_000004, 0x000005_000006, 0x000007_000008, then IDL → 4 samples in order. O_iq_ena2 only on the third word. frame_done with sample_cnt = 4. No error.
- Energy frame: M1, M3, M7, then 2 PAY words (mach 0x1234, mode 3, angle 5, energy 0x0003E8, range 0x1FFF), then 0xc5bc… → 2 target pulses with exact fields, 2 cycles after each word.
- Truncated IQ: header, then 4 PAY words, then IDL → 5 samples emitted. frame_done with cnt = 5. O_err pulse. O_err_cnt = 1.
- Broken header: M1, M3, IDL, then PAY → 2 errors (bad header, orphan payload). No data output. O_err_cnt = 2.
- Overrun and saturation: IQ_WORDS_MAX = 6 override with 7 PAY words → 8 samples and 1 error. Separately, force 0x10000 errors → O_err_cnt holds 0xFFFF.
- Reset mid-frame: I_rst asserted after 2 PAY words, then a new full frame → no frame_done for the aborted frame. The new frame decodes correctly from phase 0.

Source files
------------

// File: rtl/serdes_rx_deframer.sv
// Receive deframer: classifies lane words, tracks frame headers, unpacks IQ samples and target records.
// Latency: 2 cycles from input word to any valid/pulse output (input register + decode/output register).
// Backpressure: none; one payload word per cycle is accepted indefinitely.
module serdes_rx_deframer #(
    parameter int IQ_WORDS_MAX = 12288
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_rx_is_k,
    input  logic [15:0] I_rx1_dat,
    input  logic [15:0] I_rx2_dat,
    input  logic [15:0] I_rx3_dat,
    input  logic [15:0] I_rx4_dat,
    output logic        O_iq_ena,
    output logic [23:0] O_iq_i_dat,
    output logic [23:0] O_iq_q_dat,
    output logic        O_iq_ena2,
    output logic [23:0] O_iq_i_dat2,
    output logic [23:0] O_iq_q_dat2,
    output logic        O_iq_frame_done,
    output logic [15:0] O_iq_sample_cnt,
    output logic        O_target_ena,
    output logic [15:0] O_mach_angle_info,
    output logic [2:0]  O_mode_info,
    output logic [4:0]  O_angle_info,
    output logic [23:0] O_target_energy,
    output logic [12:0] O_target_range,
    output logic        O_err,
    output logic [15:0] O_err_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_H1, S_H2, S_IQ, S_EN} state_t;

    localparam logic [15:0] L_WMAX = 16'(IQ_WORDS_MAX);

    logic        r_is_k;
    logic [63:0] r_word;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_phase;
    logic [31:0] r_held;
    logic [15:0] r_scnt;
    logic [15:0] r_wcnt;
    logic        r_ovf;

    logic        w_pay, w_m1, w_m3, w_m5, w_m7, w_idl;
    logic        w_iq_ena, w_iq_ena2, w_done, w_tgt_ena, w_err;
    logic [47:0] w_smp_a, w_smp_b;
    logic [1:0]  w_phase_nxt;
    logic [31:0] w_held_nxt;
    logic [15:0] w_scnt_nxt;
    logic [15:0] w_wcnt_nxt;
    logic        w_ovf_nxt;

    // Stage 1: register the lane-assembled word and its K flag
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_is_k <= 1'b0;
            r_word <= '0;
        end else begin
            r_is_k <= I_rx_is_k;
            r_word <= {I_rx4_dat, I_rx3_dat, I_rx2_dat, I_rx1_dat};
        end
    end

    // Word class decode; a marker only counts when all lanes agree
    always_comb begin
        w_pay = r_is_k;
        w_m1  = !r_is_k && (r_word == {8{8'h1c}});
        w_m3  = !r_is_k && (r_word == {8{8'h3c}});
        w_m5  = !r_is_k && (r_word == {8{8'h5c}});
        w_m7  = !r_is_k && (r_word == {8{8'h7c}});
        w_idl = !r_is_k && !(w_m1 || w_m3 || w_m5 || w_m7);
    end

    // FSM state register
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic; a fresh M1 always restarts header search
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_m1) w_state_nxt = S_H1;
            S_H1:   if (w_m3) w_state_nxt = S_H2;
                    else if (!w_m1) w_state_nxt = S_IDLE;
            S_H2:   if (w_m5) w_state_nxt = S_IQ;
                    else if (w_m7) w_state_nxt = S_EN;
                    else if (w_m1) w_state_nxt = S_H1;
                    else w_state_nxt = S_IDLE;
            S_IQ, S_EN: if (w_m1) w_state_nxt = S_H1;
                    else if (!w_pay) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output/datapath logic: unpack, frame close, error detection
    always_comb begin
        w_iq_ena    = 1'b0;
        w_iq_ena2   = 1'b0;
        w_done      = 1'b0;
        w_tgt_ena   = 1'b0;
        w_err       = 1'b0;
        w_smp_a     = r_word[63:16];
        w_smp_b     = r_word[47:0];
        w_phase_nxt = r_phase;
        w_held_nxt  = r_held;
        w_scnt_nxt  = r_scnt;
        w_wcnt_nxt  = r_wcnt;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: w_err = w_pay;
            S_H1:   w_err = !(w_m3 || w_m1);
            S_H2: begin
                if (w_m5) begin
                    w_phase_nxt = 2'd0;
                    w_held_nxt  = '0;
                    w_scnt_nxt  = '0;
                    w_wcnt_nxt  = '0;
                    w_ovf_nxt   = 1'b0;
                end else begin
                    w_err = !(w_m7 || w_m1);
                end
            end
            S_IQ: begin
                if (w_pay) begin
                    if (r_wcnt < L_WMAX) begin
                        w_wcnt_nxt = r_wcnt + 16'd1;
                        w_iq_ena   = 1'b1;
                        case (r_phase)
                            2'd0: begin
                                w_smp_a     = r_word[63:16];
                                w_held_nxt  = {16'h0, r_word[15:0]};
                                w_phase_nxt = 2'd1;
                                w_scnt_nxt  = r_scnt + 16'd1;
                            end
                            2'd1: begin
                                w_smp_a     = {r_held[15:0], r_word[63:32]};
                                w_held_nxt  = r_word[31:0];
                                w_phase_nxt = 2'd2;
                                w_scnt_nxt  = r_scnt + 16'd1;
                            end
                            default: begin
                                w_smp_a     = {r_held, r_word[63:48]};
                                w_smp_b     = r_word[47:0];
                                w_iq_ena2   = 1'b1;
                                w_phase_nxt = 2'd0;
                                w_scnt_nxt  = r_scnt + 16'd2;
                            end
                        endcase
                    end else if (!r_ovf) begin
                        // Only the first dropped word of a frame is flagged
                        w_err     = 1'b1;
                        w_ovf_nxt = 1'b1;
                    end
                end else begin
                    // Any non-payload word closes the frame; leftover partial bits are lost
                    w_done      = 1'b1;
                    w_err       = (r_phase != 2'd0) || !(w_idl || w_m1);
                    w_phase_nxt = 2'd0;
                    w_held_nxt  = '0;
                end
            end
            S_EN: begin
                if (w_pay) begin
                    w_tgt_ena = 1'b1;
                    w_err     = (r_word[15:13] != 3'd0);
                end else begin
                    w_err = !(w_idl || w_m1);
                end
            end
            default: ;
        endcase
    end

    // Frame datapath state: unpack phase, held bits, sample and word counters
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_phase <= 2'd0;
            r_held  <= '0;
            r_scnt  <= '0;
            r_wcnt  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_held  <= w_held_nxt;
            r_scnt  <= w_scnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Output registers; data fields hold between valids, error count saturates
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            O_iq_ena          <= 1'b0;
            O_iq_i_dat        <= '0;
            O_iq_q_dat        <= '0;
            O_iq_ena2         <= 1'b0;
            O_iq_i_dat2       <= '0;
            O_iq_q_dat2       <= '0;
            O_iq_frame_done   <= 1'b0;
            O_iq_sample_cnt   <= '0;
            O_target_ena      <= 1'b0;
            O_mach_angle_info <= '0;
            O_mode_info       <= '0;
            O_angle_info      <= '0;
            O_target_energy   <= '0;
            O_target_range    <= '0;
            O_err             <= 1'b0;
            O_err_cnt         <= '0;
        end else begin
            O_iq_ena        <= w_iq_ena;
            O_iq_ena2       <= w_iq_ena2;
            O_iq_frame_done <= w_done;
            O_target_ena    <= w_tgt_ena;
            O_err           <= w_err;
            if (w_iq_ena) begin
                O_iq_i_dat <= w_smp_a[47:24];
                O_iq_q_dat <= w_smp_a[23:0];
            end
            if (w_iq_ena2) begin
                O_iq_i_dat2 <= w_smp_b[47:24];
                O_iq_q_dat2 <= w_smp_b[23:0];
            end
            if (w_done) O_iq_sample_cnt <= r_scnt;
            if (w_tgt_ena) begin
                O_mach_angle_info <= r_word[63:48];
                O_mode_info       <= r_word[47:45];
                O_angle_info      <= r_word[44:40];
                O_target_energy   <= r_word[39:16];
                O_target_range    <= r_word[12:0];
            end
            if (w_err && (O_err_cnt != 16'hFFFF)) O_err_cnt <= O_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_serdes_rx_deframer.sv
// Directed bench for serdes_rx_deframer: header/IQ/energy frames, truncation, overrun, saturation, reset.
// Events are logged with cycle stamps by a monitor and compared against hand-computed expectations.
// Built with IQ_WORDS_MAX = 6 so the overrun case stays short.
module tb_serdes_rx_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_k;
    logic [15:0] rx1, rx2, rx3, rx4;
    logic        iq_ena, iq_ena2, done, tgt_ena, err;
    logic [23:0] iq_i, iq_q, iq_i2, iq_q2, energy;
    logic [15:0] scnt, mach, err_cnt;
    logic [2:0]  mode;
    logic [4:0]  angle;
    logic [12:0] range_v;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int t_last;

    typedef struct { logic [47:0] s; bit b; int c; } iq_ev_t;
    typedef struct { logic [60:0] f; int c; } tgt_ev_t;
    typedef struct { logic [15:0] n; int c; } done_ev_t;

    iq_ev_t   iq_q_ev[$];
    tgt_ev_t  tgt_q[$];
    done_ev_t done_q[$];
    int       err_q[$];

    localparam logic [63:0] M1  = {8{8'h1c}};
    localparam logic [63:0] M3  = {8{8'h3c}};
    localparam logic [63:0] M5  = {8{8'h5c}};
    localparam logic [63:0] M7  = {8{8'h7c}};
    localparam logic [63:0] IDL = 64'hc5bcc5bcc5bcc5bc;
    localparam logic [63:0] W0  = 64'h0000010000020000;
    localparam logic [63:0] W1  = 64'h0300000400000500;
    localparam logic [63:0] W2  = 64'h0006000007000008;
    localparam logic [63:0] W3  = 64'h00000900000ABEEF;
    localparam logic [47:0] S0  = 48'h000001000002;
    localparam logic [47:0] S1  = 48'h000003000004;
    localparam logic [47:0] S2  = 48'h000005000006;
    localparam logic [47:0] S3  = 48'h000007000008;
    localparam logic [47:0] S4  = 48'h00000900000A;

    serdes_rx_deframer #(.IQ_WORDS_MAX(6)) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_rx_is_k(is_k),
        .I_rx1_dat(rx1), .I_rx2_dat(rx2), .I_rx3_dat(rx3), .I_rx4_dat(rx4),
        .O_iq_ena(iq_ena), .O_iq_i_dat(iq_i), .O_iq_q_dat(iq_q),
        .O_iq_ena2(iq_ena2), .O_iq_i_dat2(iq_i2), .O_iq_q_dat2(iq_q2),
        .O_iq_frame_done(done), .O_iq_sample_cnt(scnt),
        .O_target_ena(tgt_ena), .O_mach_angle_info(mach), .O_mode_info(mode),
        .O_angle_info(angle), .O_target_energy(energy), .O_target_range(range_v),
        .O_err(err), .O_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every output event with the cycle it was seen
    always @(negedge clk) begin
        iq_ev_t   e;
        tgt_ev_t  t;
        done_ev_t d;
        if (iq_ena)  begin e.s = {iq_i, iq_q};   e.b = 1'b0; e.c = cyc; iq_q_ev.push_back(e); end
        if (iq_ena2) begin e.s = {iq_i2, iq_q2}; e.b = 1'b1; e.c = cyc; iq_q_ev.push_back(e); end
        if (tgt_ena) begin t.f = {mach, mode, angle, energy, range_v}; t.c = cyc; tgt_q.push_back(t); end
        if (done)    begin d.n = scnt; d.c = cyc; done_q.push_back(d); end
        if (err)     err_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit k, input logic [63:0] w);
        is_k = k;
        {rx4, rx3, rx2, rx1} = w;
        t_last = cyc;
        @(negedge clk);
    endtask

    task automatic clear_q();
        iq_q_ev.delete(); tgt_q.delete(); done_q.delete(); err_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) send(1'b0, 64'h0);
        rst = 1'b0;
        repeat (2) send(1'b0, 64'h0);
        clear_q();
    endtask

    task automatic chk_iq(input string tag, input int i, input logic [47:0] s, input bit b, input int c);
        if (i < iq_q_ev.size()) begin
            check({tag, "_dat"}, iq_q_ev[i].s, s);
            check({tag, "_ena2"}, 64'(iq_q_ev[i].b), 64'(b));
            check({tag, "_cyc"}, 64'(iq_q_ev[i].c), 64'(c));
        end
    endtask

    // Header M1,M3,M5 then W0,W1,W2 and IDL; returns drive cycles of the three words and the closer
    task automatic iq_frame(output int c0, output int c1, output int c2, output int cc);
        send(1'b0, M1); send(1'b0, M3); send(1'b0, M5);
        send(1'b1, W0); c0 = t_last;
        send(1'b1, W1); c1 = t_last;
        send(1'b1, W2); c2 = t_last;
        send(1'b0, 64'h0); cc = t_last;
        repeat (3) send(1'b0, 64'h0);
    endtask

    initial begin
        int c0, c1, c2, c3, cc;
        logic [60:0] t0, t1;
        rst = 1'b1; is_k = 1'b0; {rx4, rx3, rx2, rx1} = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_err_cnt", 64'(err_cnt), 64'h0);
        check("rst_iq_i", 64'(iq_i), 64'h0);
        check("rst_ena", 64'({iq_ena, iq_ena2, done, tgt_ena, err}), 64'h0);
        check("rst_energy", 64'(energy), 64'h0);
        check("rst_scnt", 64'(scnt), 64'h0);

        // Basic IQ frame: 3 words -> 4 samples
        iq_frame(c0, c1, c2, cc);
        check("iq1_n", 64'(iq_q_ev.size()), 64'd4);
        chk_iq("iq1_s0", 0, S0, 1'b0, c0 + 2);
        chk_iq("iq1_s1", 1, S1, 1'b0, c1 + 2);
        chk_iq("iq1_s2", 2, S2, 1'b0, c2 + 2);
        chk_iq("iq1_s3", 3, S3, 1'b1, c2 + 2);
        check("iq1_done_n", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) begin
            check("iq1_cnt", 64'(done_q[0].n), 64'd4);
            check("iq1_done_cyc", 64'(done_q[0].c), 64'(cc + 2));
        end
        check("iq1_err_n", 64'(err_q.size()), 64'd0);
        check("iq1_hold_i", 64'(iq_i), 64'h000005);
        check("iq1_hold_q2", 64'(iq_q2), 64'h000008);

        // Energy frame: 2 target records then 0xc5bc idle
        do_reset();
        t0 = {16'h1234, 3'd3, 5'd5, 24'h0003E8, 13'h1FFF};
        t1 = {16'hABCD, 3'd7, 5'd31, 24'hFFFFFF, 13'h0000};
        send(1'b0, M1); send(1'b0, M3); send(1'b0, M7);
        send(1'b1, 64'h1234650003E81FFF); c0 = t_last;
        send(1'b1, 64'hABCDFFFFFFFF0000); c1 = t_last;
        send(1'b0, IDL);
        repeat (3) send(1'b0, 64'h0);
        check("en_n", 64'(tgt_q.size()), 64'd2);
        if (tgt_q.size() == 2) begin
            check("en_t0", 64'(tgt_q[0].f), 64'(t0));
            check("en_t0_cyc", 64'(tgt_q[0].c), 64'(c0 + 2));
            check("en_t1", 64'(tgt_q[1].f), 64'(t1));
            check("en_t1_cyc", 64'(tgt_q[1].c), 64'(c1 + 2));
        end
        check("en_err_n", 64'(err_q.size()), 64'd0);
        check("en_iq_n", 64'(iq_q_ev.size() + done_q.size()), 64'd0);

        // Truncated IQ: 4 words -> 5 samples, close at phase 1 is an error
        do_reset();
        send(1'b0, M1); send(1'b0, M3); send(1'b0, M5);
        send(1'b1, W0); send(1'b1, W1); send(1'b1, W2);
        send(1'b1, W3); c3 = t_last;
        send(1'b0, 64'h0); cc = t_last;
        repeat (3) send(1'b0, 64'h0);
        check("tr_n", 64'(iq_q_ev.size()), 64'd5);
        chk_iq("tr_s4", 4, S4, 1'b0, c3 + 2);
        check("tr_done_n", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) check("tr_cnt", 64'(done_q[0].n), 64'd5);
        check("tr_err_n", 64'(err_q.size()), 64'd1);
        if (err_q.size() > 0) check("tr_err_cyc", 64'(err_q[0]), 64'(cc + 2));
        check("tr_err_cnt", 64'(err_cnt), 64'd1);

        // Broken header then orphan payload
        do_reset();
        send(1'b0, M1); send(1'b0, M3);
        send(1'b0, IDL); c0 = t_last;
        send(1'b1, W0); c1 = t_last;
        repeat (3) send(1'b0, 64'h0);
        check("bh_err_n", 64'(err_q.size()), 64'd2);
        if (err_q.size() == 2) begin
            check("bh_err0_cyc", 64'(err_q[0]), 64'(c0 + 2));
            check("bh_err1_cyc", 64'(err_q[1]), 64'(c1 + 2));
        end
        check("bh_data_n", 64'(iq_q_ev.size() + tgt_q.size() + done_q.size()), 64'd0);
        check("bh_err_cnt", 64'(err_cnt), 64'd2);

        // Overrun with limit 6: 7th word dropped with a single error
        do_reset();
        send(1'b0, M1); send(1'b0, M3); send(1'b0, M5);
        send(1'b1, W0); send(1'b1, W1); send(1'b1, W2);
        send(1'b1, W0); send(1'b1, W1); send(1'b1, W2);
        send(1'b1, W0); c0 = t_last;
        send(1'b0, 64'h0);
        repeat (3) send(1'b0, 64'h0);
        check("ov_n", 64'(iq_q_ev.size()), 64'd8);
        chk_iq("ov_s7", 7, S3, 1'b1, c0 + 1);
        check("ov_err_n", 64'(err_q.size()), 64'd1);
        if (err_q.size() > 0) check("ov_err_cyc", 64'(err_q[0]), 64'(c0 + 2));
        if (done_q.size() > 0) check("ov_cnt", 64'(done_q[0].n), 64'd8);
        check("ov_done_n", 64'(done_q.size()), 64'd1);

        // Error counter saturation via orphan payload words
        do_reset();
        for (int i = 0; i < 65540; i++) send(1'b1, 64'(i));
        repeat (3) send(1'b0, 64'h0);
        check("sat_err_cnt", 64'(err_cnt), 64'hFFFF);

        // Reset mid-frame, then a clean frame from phase 0
        do_reset();
        send(1'b0, M1); send(1'b0, M3); send(1'b0, M5);
        send(1'b1, W0); send(1'b1, W1);
        do_reset();
        check("mr_rst_i", 64'(iq_i), 64'h0);
        check("mr_rst_cnt", 64'(err_cnt), 64'h0);
        iq_frame(c0, c1, c2, cc);
        check("mr_n", 64'(iq_q_ev.size()), 64'd4);
        chk_iq("mr_s0", 0, S0, 1'b0, c0 + 2);
        chk_iq("mr_s3", 3, S3, 1'b1, c2 + 2);
        check("mr_done_n", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) check("mr_done_cyc", 64'(done_q[0].c), 64'(cc + 2));
        check("mr_err_n", 64'(err_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
